// File: rtl/game_mode_pkg.sv
// Shared types and constants for the game mode arbiter.
// Latency: n/a (types only).
// Backpressure: n/a.
package game_mode_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        HOLD  = 2'd2
    } gma_state_t;

    localparam logic MODE_CLASSIC  = 1'b0;
    localparam logic MODE_ENHANCED = 1'b1;

    function automatic logic [1:0] mode_onehot(input logic m);
        return (m == MODE_ENHANCED) ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/select_debouncer.sv
// Synchronises the raw mode switch and debounces it into sel_stable.
// Latency: 2 sync cycles + DEBOUNCE_CYCLES stable cycles before sel_stable follows.
// Backpressure: none; free-running input conditioner.
module select_debouncer
    import game_mode_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic select,
    output logic sel_stable
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    sync_q, sync_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          sel_stable_q, sel_stable_d;
    logic          select_sync;

    assign select_sync = sync_q[1];
    assign sel_stable  = sel_stable_q;

    always_comb begin
        sync_d       = {sync_q[0], select};
        cnt_d        = cnt_q;
        sel_stable_d = sel_stable_q;
        // Any return to the current stable level restarts the qualification window.
        if (select_sync == sel_stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == DB_LAST) begin
            sel_stable_d = select_sync;
            cnt_d        = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q       <= 2'b00;
            cnt_q        <= '0;
            sel_stable_q <= 1'b0;
        end else begin
            sync_q       <= sync_d;
            cnt_q        <= cnt_d;
            sel_stable_q <= sel_stable_d;
        end
    end

endmodule

// File: rtl/game_mode_arbiter.sv
// Hands the shared keypad/display/LED between the two game cores; GMA_DRAIN_TIMEOUT_EN adds a forced-switch drain timeout.
// Latency: sel_stable toggle -> new game_en after RST_CYCLES+2 cycles when the active game is idle.
// Backpressure: game_busy of the active game stalls the switch in DRAIN.
module game_mode_arbiter
    import game_mode_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int RST_CYCLES      = 16,
    parameter int DRAIN_TIMEOUT   = 1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       select,
    input  logic [1:0] game_busy,
    output logic [1:0] game_en,
    output logic [1:0] game_rst_n,
    output logic       mode,
    output logic       switching,
    output logic [7:0] switch_cnt
);

    localparam int HW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(RST_CYCLES - 1);

    if (RST_CYCLES < 1 || DRAIN_TIMEOUT < 1 || DRAIN_TIMEOUT > 2048) begin : g_param_check
        $error("game_mode_arbiter: RST_CYCLES must be >= 1 and DRAIN_TIMEOUT in 1..2048");
    end

    logic          sel_stable;
    gma_state_t    state_q, state_d;
    logic          mode_q, mode_d;
    logic          target_q, target_d;
    logic [HW-1:0] hold_cnt_q, hold_cnt_d;
    logic [7:0]    switch_cnt_q, switch_cnt_d;
    logic [1:0]    game_en_q, game_en_d;
    logic [1:0]    game_rst_n_q, game_rst_n_d;
    logic          switching_q, switching_d;
`ifdef GMA_DRAIN_TIMEOUT_EN
    localparam logic [10:0] DRAIN_LAST = 11'(DRAIN_TIMEOUT - 1);
    logic [10:0]   drain_cnt_q, drain_cnt_d;
`endif

    select_debouncer #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_select_debouncer (
        .clk        (clk),
        .rst        (rst),
        .select     (select),
        .sel_stable (sel_stable)
    );

    always_comb begin
        state_d      = state_q;
        mode_d       = mode_q;
        target_d     = target_q;
        hold_cnt_d   = hold_cnt_q;
        switch_cnt_d = switch_cnt_q;
`ifdef GMA_DRAIN_TIMEOUT_EN
        drain_cnt_d  = drain_cnt_q;
`endif
        case (state_q)
            RUN: begin
                if (sel_stable != mode_q) begin
                    state_d  = DRAIN;
                    target_d = sel_stable;
`ifdef GMA_DRAIN_TIMEOUT_EN
                    drain_cnt_d = '0;
`endif
                end
            end
            DRAIN: begin
                if (sel_stable == mode_q) begin
                    state_d = RUN;
                end else if (!game_busy[mode_q]) begin
                    state_d    = HOLD;
                    hold_cnt_d = '0;
                end
`ifdef GMA_DRAIN_TIMEOUT_EN
                else if (drain_cnt_q == DRAIN_LAST) begin
                    state_d    = HOLD;
                    hold_cnt_d = '0;
                end else begin
                    drain_cnt_d = drain_cnt_q + 1'b1;
                end
`endif
            end
            HOLD: begin
                if (hold_cnt_q == HOLD_LAST) begin
                    state_d = RUN;
                    mode_d  = target_q;
                    // The post-reset HOLD has target == mode, so it is not counted.
                    if (target_q != mode_q && switch_cnt_q != 8'hFF) begin
                        switch_cnt_d = switch_cnt_q + 1'b1;
                    end
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            default: state_d = HOLD;
        endcase

        // Outputs are registered from the next state so the cores see glitch-free enables.
        game_en_d    = 2'b00;
        game_rst_n_d = 2'b00;
        switching_d  = (state_d != RUN);
        if (state_d != HOLD) begin
            game_en_d    = mode_onehot(mode_d);
            game_rst_n_d = mode_onehot(mode_d);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= HOLD;
            mode_q       <= MODE_CLASSIC;
            target_q     <= MODE_CLASSIC;
            hold_cnt_q   <= '0;
            switch_cnt_q <= 8'd0;
            game_en_q    <= 2'b00;
            game_rst_n_q <= 2'b00;
            switching_q  <= 1'b1;
`ifdef GMA_DRAIN_TIMEOUT_EN
            drain_cnt_q  <= '0;
`endif
        end else begin
            state_q      <= state_d;
            mode_q       <= mode_d;
            target_q     <= target_d;
            hold_cnt_q   <= hold_cnt_d;
            switch_cnt_q <= switch_cnt_d;
            game_en_q    <= game_en_d;
            game_rst_n_q <= game_rst_n_d;
            switching_q  <= switching_d;
`ifdef GMA_DRAIN_TIMEOUT_EN
            drain_cnt_q  <= drain_cnt_d;
`endif
        end
    end

    assign game_en    = game_en_q;
    assign game_rst_n = game_rst_n_q;
    assign mode       = mode_q;
    assign switching  = switching_q;
    assign switch_cnt = switch_cnt_q;

endmodule
